// File: rtl/data_bus_responder.sv
// Word-addressed load/store responder: accepts one request at a time, waits WAIT_STATES
// cycles, then returns a single-cycle registered response with optional error flag.
module data_bus_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        mem_write_i,
    input  logic        mem_read_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  byte_en_i,
    output logic        rsp_valid_o,
    output logic [31:0] read_data_o,
    output logic        rsp_err_o
);

    localparam int unsigned IdxW     = $clog2(DEPTH);
    localparam logic [3:0]  WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        wr_q;
    logic        rd_q;

    logic        rsp_valid_q;
    logic [31:0] read_data_q;
    logic        rsp_err_q;

    logic [31:0] mem_q [DEPTH];

    logic        in_idle;
    logic        cap_en;
    logic        enter_resp;

    // With zero wait states the response is formed on the accept edge itself, so the
    // request fields come straight from the inputs in IDLE and from the capture regs after.
    logic [31:0]     cur_addr;
    logic [31:0]     cur_wdata;
    logic [3:0]      cur_be;
    logic            cur_wr;
    logic            cur_rd;
    logic            cur_oob;
    logic            cur_err;
    logic [IdxW-1:0] cur_idx;

    assign in_idle     = (state_q == StIdle);
    assign req_ready_o = in_idle && rst_ni;

    assign cur_addr  = in_idle ? address_i    : addr_q;
    assign cur_wdata = in_idle ? write_data_i : wdata_q;
    assign cur_be    = in_idle ? byte_en_i    : be_q;
    assign cur_wr    = in_idle ? mem_write_i  : wr_q;
    assign cur_rd    = in_idle ? mem_read_i   : rd_q;

    assign cur_idx = cur_addr[IdxW+1:2];
    assign cur_oob = (cur_addr[31:IdxW+2] != '0);
    assign cur_err = (cur_addr[1:0] != 2'b00) || cur_oob || (cur_wr == cur_rd);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_en     = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i && req_ready_o) begin
                    cap_en = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            read_data_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap_en) begin
                addr_q  <= address_i;
                wdata_q <= write_data_i;
                be_q    <= byte_en_i;
                wr_q    <= mem_write_i;
                rd_q    <= mem_read_i;
            end
            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= cur_err;
                read_data_q <= (cur_rd && !cur_err) ? mem_q[cur_idx] : '0;
            end else begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                read_data_q <= '0;
            end
        end
    end

    // Storage is not reset; the rst_ni term stops a commit on an edge where reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_ni && enter_resp && cur_wr && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem_q[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign read_data_o = read_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed, randomized and reset-abort scenarios on a
// WAIT_STATES=1 instance plus back-to-back streaming on a WAIT_STATES=0 instance.
module tb_data_bus_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned WS1   = 1;

    logic clk;
    logic rst_n;

    logic        req_valid, req_ready, mem_write, mem_read, rsp_valid, rsp_err;
    logic [31:0] address, write_data, read_data;
    logic [3:0]  byte_en;

    logic        req_valid0, req_ready0, mem_write0, mem_read0, rsp_valid0, rsp_err0;
    logic [31:0] address0, write_data0, read_data0;
    logic [3:0]  byte_en0;

    int checks = 0;
    int errors = 0;

    logic [31:0] model1 [DEPTH];
    logic [31:0] model0 [DEPTH];

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    data_bus_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .mem_write_i  (mem_write),
        .mem_read_i   (mem_read),
        .address_i    (address),
        .write_data_i (write_data),
        .byte_en_i    (byte_en),
        .rsp_valid_o  (rsp_valid),
        .read_data_o  (read_data),
        .rsp_err_o    (rsp_err)
    );

    data_bus_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid0),
        .req_ready_o  (req_ready0),
        .mem_write_i  (mem_write0),
        .mem_read_i   (mem_read0),
        .address_i    (address0),
        .write_data_i (write_data0),
        .byte_en_i    (byte_en0),
        .rsp_valid_o  (rsp_valid0),
        .read_data_o  (read_data0),
        .rsp_err_o    (rsp_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: error if misaligned, out of range, or not exactly one of load/store.
    task automatic model1_txn(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] be,
                              output logic [31:0] ed, output logic ee);
        int unsigned idx;
        idx = addr >> 2;
        ed  = '0;
        ee  = (addr[1:0] != 2'b00) || (idx >= DEPTH) || (wr == rd);
        if (!ee && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model1[idx][8*i +: 8] = wd[8*i +: 8];
            end
        end else if (!ee && rd) begin
            ed = model1[idx];
        end
    endtask

    task automatic garbage1();
        req_valid  = 1'b1;
        mem_write  = 1'($urandom);
        mem_read   = 1'($urandom);
        address    = $urandom;
        write_data = $urandom;
        byte_en    = 4'($urandom);
    endtask

    // Issues one request to u_dut and collects its response; lat = -1 on timeout.
    task automatic run_txn(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be,
                           output logic [31:0] rdata, output logic rerr,
                           output int lat, output logic proto_ok);
        proto_ok = 1'b1;
        rdata    = '0;
        rerr     = 1'b0;
        lat      = -1;
        @(negedge clk);
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) proto_ok = 1'b0;
        req_valid  = 1'b1;
        mem_write  = wr;
        mem_read   = rd;
        address    = addr;
        write_data = wd;
        byte_en    = be;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (req_ready !== 1'b0) proto_ok = 1'b0;
            if (rsp_valid === 1'b1) begin
                lat   = n;
                rdata = read_data;
                rerr  = rsp_err;
                break;
            end
            garbage1();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        mem_write  = 1'b1;
        mem_read   = 1'b0;
        address    = 32'h10;
        write_data = 32'hFFFF_FFFF;
        byte_en    = 4'hF;
        req_valid0 = 1'b1;
        mem_write0 = 1'b0;
        mem_read0  = 1'b1;
        address0   = 32'h10;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || req_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b/%b exp 0/0", req_ready, req_ready0);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b e=%b d=%h exp 0", rsp_valid, rsp_err,
                     read_data);
        end
        req_valid  = 1'b0;
        req_valid0 = 1'b0;
        rst_n      = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got %b/%b exp 1/1", req_ready, req_ready0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || rsp_valid0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_accept cycle %0d got %b/%b exp 0/0", c, rsp_valid,
                         rsp_valid0);
            end
        end
    endtask

    task automatic test_directed();
        vec_t vecs [12] = '{
            '{1'b1, 1'b0, 32'h10,  32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0},
            '{1'b0, 1'b1, 32'h10,  32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0},
            '{1'b1, 1'b0, 32'h10,  32'h0000_00AA, 4'h1, 32'h0,         1'b0},
            '{1'b0, 1'b1, 32'h10,  32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0},
            '{1'b0, 1'b1, 32'h12,  32'h0,         4'h0, 32'h0,         1'b1},
            '{1'b0, 1'b1, 32'h100, 32'h0,         4'h0, 32'h0,         1'b1},
            '{1'b0, 1'b1, 32'h10,  32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0},
            '{1'b1, 1'b1, 32'h10,  32'h0,         4'hF, 32'h0,         1'b1},
            '{1'b0, 1'b0, 32'h10,  32'h0,         4'hF, 32'h0,         1'b1},
            '{1'b1, 1'b0, 32'h10,  32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0},
            '{1'b1, 1'b0, 32'h14,  32'h5555_5555, 4'hF, 32'h0,         1'b0},
            '{1'b0, 1'b1, 32'h10,  32'h0,         4'h5, 32'hDEAD_BEAA, 1'b0}
        };
        logic [31:0] d;
        logic        e;
        logic        p;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].be, d, e, lat, p);
            checks++;
            if (lat != int'(WS1) + 1) begin
                errors++;
                $display("FAIL dir[%0d] latency got %0d exp %0d", i, lat, int'(WS1) + 1);
            end
            checks++;
            if (d !== vecs[i].ed) begin
                errors++;
                $display("FAIL dir[%0d] read_data got %h exp %h", i, d, vecs[i].ed);
            end
            checks++;
            if (e !== vecs[i].ee) begin
                errors++;
                $display("FAIL dir[%0d] rsp_err got %b exp %b", i, e, vecs[i].ee);
            end
            checks++;
            if (p !== 1'b1) begin
                errors++;
                $display("FAIL dir[%0d] handshake got ready/valid violation exp none", i);
            end
        end
    endtask

    task automatic test_init();
        logic [31:0] d, wd;
        logic        e, p;
        int          lat;
        for (int i = 0; i < int'(DEPTH); i++) begin
            wd = $urandom;
            model1[i] = wd;
            run_txn(1'b1, 1'b0, 32'(i) << 2, wd, 4'hF, d, e, lat, p);
            checks++;
            if (e !== 1'b0 || d !== 32'h0 || lat != int'(WS1) + 1 || p !== 1'b1) begin
                errors++;
                $display("FAIL init[%0d] got err=%b data=%h lat=%0d proto=%b exp 0/0/%0d/1",
                         i, e, d, lat, p, int'(WS1) + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wd, d, ed;
        logic [3:0]  be;
        logic        wr, rd, e, ee, p;
        int          lat, r;
        for (int t = 0; t < 300; t++) begin
            r    = int'($urandom_range(0, 99));
            addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
            wd   = $urandom;
            be   = 4'($urandom);
            wr   = 1'($urandom);
            rd   = ~wr;
            if (r < 45) begin
                wr = 1'b0;
                rd = 1'b1;
            end else if (r < 80) begin
                wr = 1'b1;
                rd = 1'b0;
            end else if (r < 85) begin
                addr = addr | 32'($urandom_range(1, 3));
            end else if (r < 90) begin
                addr = (32'(DEPTH) + 32'($urandom_range(0, 4000))) << 2;
            end else if (r < 95) begin
                wr = 1'b1;
                rd = 1'b1;
            end else begin
                wr = 1'b0;
                rd = 1'b0;
            end
            model1_txn(wr, rd, addr, wd, be, ed, ee);
            run_txn(wr, rd, addr, wd, be, d, e, lat, p);
            checks++;
            if (d !== ed) begin
                errors++;
                $display("FAIL rnd[%0d] read_data got %h exp %h (wr=%b rd=%b a=%h)", t, d, ed,
                         wr, rd, addr);
            end
            checks++;
            if (e !== ee) begin
                errors++;
                $display("FAIL rnd[%0d] rsp_err got %b exp %b (a=%h)", t, e, ee, addr);
            end
            checks++;
            if (lat != int'(WS1) + 1 || p !== 1'b1) begin
                errors++;
                $display("FAIL rnd[%0d] timing got lat=%0d proto=%b exp %0d/1", t, lat, p,
                         int'(WS1) + 1);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] d, x;
        logic        e, p;
        int          lat;
        logic        quiet;
        x = 32'hCAFE_0000 | 32'($urandom_range(0, 16'hFFFF));
        model1[8] = x;
        run_txn(1'b1, 1'b0, 32'h20, x, 4'hF, d, e, lat, p);
        @(negedge clk);
        req_valid  = 1'b1;
        mem_write  = 1'b1;
        mem_read   = 1'b0;
        address    = 32'h20;
        write_data = 32'h1234_5678;
        byte_en    = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        quiet     = 1'b1;
        @(negedge clk);
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) quiet = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_response got a response or ready during reset exp none");
        end
        run_txn(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, d, e, lat, p);
        checks++;
        if (d !== x || e !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_commit got %h err=%b exp %h err=0", d, e, x);
        end
        run_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, d, e, lat, p);
        model1[8] = 32'h0;
        run_txn(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, d, e, lat, p);
        checks++;
        if (d !== 32'h0 || e !== 1'b0 || lat != int'(WS1) + 1) begin
            errors++;
            $display("FAIL abort_reload got %h err=%b lat=%0d exp 0 err=0 lat=%0d", d, e, lat,
                     int'(WS1) + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic        pending;
        int          k;
        int unsigned a;
        logic [31:0] exp_d, wd;
        pending = 1'b0;
        k       = 0;
        a       = 0;
        exp_d   = '0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready0 !== !pending) begin
                errors++;
                $display("FAIL b2b[%0d] req_ready got %b exp %b", c, req_ready0, !pending);
            end
            checks++;
            if (rsp_valid0 !== pending) begin
                errors++;
                $display("FAIL b2b[%0d] rsp_valid got %b exp %b", c, rsp_valid0, pending);
            end
            if (pending) begin
                checks++;
                if (read_data0 !== exp_d || rsp_err0 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b[%0d] response got %h err=%b exp %h err=0", c,
                             read_data0, rsp_err0, exp_d);
                end
            end
            req_valid0 = 1'b1;
            if (!pending) begin
                if (k % 2 == 0) begin
                    a           = $urandom_range(0, DEPTH - 1);
                    wd          = $urandom;
                    model0[a]   = wd;
                    mem_write0  = 1'b1;
                    mem_read0   = 1'b0;
                    write_data0 = wd;
                    byte_en0    = 4'hF;
                    exp_d       = 32'h0;
                end else begin
                    mem_write0  = 1'b0;
                    mem_read0   = 1'b1;
                    write_data0 = $urandom;
                    byte_en0    = 4'($urandom);
                    exp_d       = model0[a];
                end
                address0 = 32'(a) << 2;
                k++;
                pending = 1'b1;
            end else begin
                mem_write0  = 1'($urandom);
                mem_read0   = 1'($urandom);
                address0    = $urandom;
                write_data0 = $urandom;
                byte_en0    = 4'($urandom);
                pending     = 1'b0;
            end
        end
        req_valid0 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        address     = '0;
        write_data  = '0;
        byte_en     = '0;
        req_valid0  = 1'b0;
        mem_write0  = 1'b0;
        mem_read0   = 1'b0;
        address0    = '0;
        write_data0 = '0;
        byte_en0    = '0;
        test_reset();
        test_directed();
        test_init();
        test_random();
        test_reset_in_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "bench timeout");
    end

endmodule
